nic_msg_arbiter: RTL and testbench
==================================

# nic_msg_arbiter

Per-application sequencer for the congestion/scale-down performance monitors. It configures, resets and re-arms a bank of `NUM_APPS` monitors. It buffers the one-cycle NIC-CPU hint pulses they emit in per-app 2-entry FIFOs and serializes them, round-robin, onto a single valid/ready message channel toward the host message path.

## Interface
Parameters:
- `APP_ID_WIDTH`, 2: app index width; `NUM_APPS = 2**APP_ID_WIDTH`.
- `MSG_WIDTH`, 64: hint message width; equals `NIC_MSG_WIDTH`.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mon_msg_en` in NUM_APPS: per-monitor one-cycle message strobe.
- `mon_msg` in NUM_APPS*MSG_WIDTH: per-monitor message; app i occupies bits `[i*MSG_WIDTH +: MSG_WIDTH]`.
- `out_valid` out 1: message available.
- `out_ready` in 1: downstream accepts.
- `out_msg` out MSG_WIDTH: message payload.
- `out_app_id` out APP_ID_WIDTH: source app of `out_msg`.
- `cfg_valid` in 1: configuration command strobe.
- `cfg_reset` in 1: command is reset (1) or configure (0).
- `cfg_app_mask` in NUM_APPS: target apps.
- `cfg_scale_down_epoch_log` in 5, `cfg_cong_epoch_log` in 5, `cfg_scale_down_thresh` in 4: config values.
- `mon_config` out NUM_APPS, `mon_reset` out NUM_APPS: per-app one-cycle pulses.
- `mon_scale_down_epoch_log` out 5, `mon_cong_epoch_log` out 5, `mon_scale_down_thresh` out 4: shared config bus, held until next configure.
- `arm_valid` in 1, `arm_app_id` in APP_ID_WIDTH, `arm_cong` in 1, `arm_scale_down` in 1: host re-arm request.
- `mon_arm_cong` out NUM_APPS, `mon_arm_scale_down` out NUM_APPS: per-app one-cycle arm pulses.
- `drop_cnt` out 16, `fwd_cnt` out 32: statistics (see Configuration).

## Operation
- Reset values: every output 0, all FIFOs empty, RR pointer 0.
- FIFO: one 2-entry FIFO per app. `mon_msg_en[i]` pushes `mon_msg` slice i.
  - Push into a full FIFO with no same-cycle pop: the message is dropped and `drop_cnt` increments.
  - Push and pop on a full FIFO in the same cycle: the push is accepted.
- Arbiter: round-robin over non-empty FIFOs, starting at the RR pointer. After a grant to app k, the pointer becomes k+1 mod NUM_APPS. A grant occurs only when the output register is loadable (`!out_valid || out_ready`). A grant pops the head into `out_msg`/`out_app_id`, sets `out_valid`, and increments `fwd_cnt`.
- Output: `out_msg`/`out_app_id` are stable while `out_valid && !out_ready`. `out_valid` clears after a handshake when no FIFO is non-empty.
- Configure (`cfg_valid && !cfg_reset`):
  - Next edge: latch the three config values onto the `mon_*` bus.
  - The following cycle: pulse `mon_config[i]` for each mask bit.
- Reset (`cfg_valid && cfg_reset`):
  - Next edge: pulse `mon_reset[i]` for each masked app.
  - On the same edge, flush those FIFOs. A flush beats a simultaneous push; flushed apps are excluded from arbitration that cycle.
  - An already-loaded output entry is unaffected.
- Arm: `arm_valid` pulses `mon_arm_cong[arm_app_id]` and/or `mon_arm_scale_down[arm_app_id]` per the request bits, one cycle later. Bits of 0 produce no pulse.
- Counters: `drop_cnt` saturates at 16'hFFFF; `fwd_cnt` wraps.

## Timing
- Message latency: `mon_msg_en` high in cycle t, with the FIFO empty, no other requester and the output idle, gives `out_valid` in cycle t+2. Throughput is one message per cycle under continuous `out_ready`.
- Config: `cfg_valid` in cycle t gives the bus valid from cycle t+1 and `mon_config` high in cycle t+2, so the bus is stable before the pulse. `mon_reset` is high in cycle t+1.
- Arm: `arm_valid` in cycle t gives the arm pulse in cycle t+1.
- Asserting `rst` mid-transfer immediately clears `out_valid` and discards all FIFO contents.

## Configuration
- `NIC_MSG_ARB_STATS_EN`:
  - Defined: `drop_cnt`/`fwd_cnt` are implemented as specified.
  - Undefined: both outputs are tied to 0, no counter flops exist, and all other behaviour is identical.

## Test plan
- Single message: app 2 pulses once with msg 64'h0001_0002_0000_0001 at cycle 10, `out_ready`=1 → `out_valid` at cycle 12 with that msg and `out_app_id`=2; `fwd_cnt`=1.
- Fairness: all 4 apps pulse in the same cycle, `out_ready`=1 → four consecutive outputs with app ids 0,1,2,3; a repeat burst then starts at app 0.
- Backpressure/overflow: `out_ready`=0, app 1 pulses 4 times (the first of which loads the output register) → `out_msg` stays stable; `drop_cnt`=1 (2 held in FIFO, 1 in output reg, 1 dropped); releasing ready yields exactly 3 messages in order.
- Configure: `cfg_valid`, mask 4'b0101, epoch logs 10/12, thresh 3 → bus 10/12/3 at t+1; `mon_config`=4'b0101 for one cycle at t+2.
- Reset flush: app 3 FIFO holds 2 entries, cfg reset with mask 4'b1000 coincident with a new app-3 pulse → `mon_reset[3]` at t+1; no app-3 messages ever emerge.
- Arm: `arm_valid`, app 1, cong=1, scale_down=0 → `mon_arm_cong`=4'b0010 for exactly one cycle at t+1; `mon_arm_scale_down` stays 0.

Source files
------------

// File: rtl/nic_msg_arbiter.sv
// nic_msg_arbiter: sequencer for a bank of congestion/scale-down monitors.
// It buffers one-cycle hint pulses in per-app 2-entry FIFOs and serializes
// them round-robin onto one valid/ready channel. It also drives the
// configure/reset/arm pulses toward the monitors.
// Optional feature macro: NIC_MSG_ARB_STATS_EN enables the drop_cnt/fwd_cnt
// statistics counters. When it is undefined, both outputs are tied to 0.
module nic_msg_arbiter #(
    parameter int APP_ID_WIDTH = 2,
    parameter int MSG_WIDTH    = 64,
    localparam int NUM_APPS    = 2**APP_ID_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_APPS-1:0]           mon_msg_en,
    input  logic [NUM_APPS*MSG_WIDTH-1:0] mon_msg,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MSG_WIDTH-1:0]          out_msg,
    output logic [APP_ID_WIDTH-1:0]       out_app_id,
    input  logic                          cfg_valid,
    input  logic                          cfg_reset,
    input  logic [NUM_APPS-1:0]           cfg_app_mask,
    input  logic [4:0]                    cfg_scale_down_epoch_log,
    input  logic [4:0]                    cfg_cong_epoch_log,
    input  logic [3:0]                    cfg_scale_down_thresh,
    output logic [NUM_APPS-1:0]           mon_config,
    output logic [NUM_APPS-1:0]           mon_reset,
    output logic [4:0]                    mon_scale_down_epoch_log,
    output logic [4:0]                    mon_cong_epoch_log,
    output logic [3:0]                    mon_scale_down_thresh,
    input  logic                          arm_valid,
    input  logic [APP_ID_WIDTH-1:0]       arm_app_id,
    input  logic                          arm_cong,
    input  logic                          arm_scale_down,
    output logic [NUM_APPS-1:0]           mon_arm_cong,
    output logic [NUM_APPS-1:0]           mon_arm_scale_down,
    output logic [15:0]                   drop_cnt,
    output logic [31:0]                   fwd_cnt
);

    localparam int CNT_W = APP_ID_WIDTH + 1;

    logic [MSG_WIDTH-1:0]    fifo_mem [NUM_APPS][2];
    logic [1:0]              fifo_cnt [NUM_APPS];
    logic [NUM_APPS-1:0]     rd_ptr;
    logic [NUM_APPS-1:0]     wr_ptr;
    logic [NUM_APPS-1:0]     flush;
    logic [NUM_APPS-1:0]     push;
    logic [NUM_APPS-1:0]     pop;
    logic [APP_ID_WIDTH-1:0] rr_ptr;
    logic [APP_ID_WIDTH-1:0] scan_idx;
    logic [APP_ID_WIDTH-1:0] gnt_idx;
    logic                    gnt;
    logic                    loadable;
    logic [MSG_WIDTH-1:0]    head_msg;
    logic [NUM_APPS-1:0]     cfg_mask_p1;

    // Round-robin pick of the first non-empty, non-flushed FIFO from rr_ptr
    always_comb begin
        flush    = (cfg_valid && cfg_reset) ? cfg_app_mask : '0;
        loadable = !out_valid || out_ready;
        gnt      = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int j = 0; j < NUM_APPS; j++) begin
            scan_idx = rr_ptr + APP_ID_WIDTH'(j);
            if (!gnt && loadable && (fifo_cnt[scan_idx] != 2'd0) && !flush[scan_idx]) begin
                gnt     = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        head_msg = fifo_mem[gnt_idx][rd_ptr[gnt_idx]];
    end

    // Per-app push/pop; a full FIFO still accepts a push when it pops that cycle
    always_comb begin
        pop  = '0;
        push = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            pop[i]  = gnt && (gnt_idx == APP_ID_WIDTH'(i));
            push[i] = mon_msg_en[i] && !flush[i] && ((fifo_cnt[i] != 2'd2) || pop[i]);
        end
    end

    // FIFO pointers and occupancy; flush wins over any push in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < NUM_APPS; i++) fifo_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_APPS; i++) begin
                if (flush[i]) begin
                    fifo_cnt[i] <= 2'd0;
                    rd_ptr[i]   <= 1'b0;
                    wr_ptr[i]   <= 1'b0;
                end else begin
                    if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
                    if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
                    fifo_cnt[i] <= fifo_cnt[i] + 2'(push[i]) - 2'(pop[i]);
                end
            end
        end
    end

    // FIFO payload storage; validity is tracked by fifo_cnt, so no reset here
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_APPS; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= mon_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end
    end

    // Output register: loads on grant, holds under backpressure, idles otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_msg    <= '0;
            out_app_id <= '0;
            rr_ptr     <= '0;
        end else if (loadable) begin
            out_valid <= gnt;
            if (gnt) begin
                out_msg    <= head_msg;
                out_app_id <= gnt_idx;
                rr_ptr     <= gnt_idx + 1'b1;
            end
        end
    end

    // Config bus latch, delayed config pulse, reset pulse and arm pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mon_scale_down_epoch_log <= '0;
            mon_cong_epoch_log       <= '0;
            mon_scale_down_thresh    <= '0;
            cfg_mask_p1              <= '0;
            mon_config               <= '0;
            mon_reset                <= '0;
            mon_arm_cong             <= '0;
            mon_arm_scale_down       <= '0;
        end else begin
            if (cfg_valid && !cfg_reset) begin
                mon_scale_down_epoch_log <= cfg_scale_down_epoch_log;
                mon_cong_epoch_log       <= cfg_cong_epoch_log;
                mon_scale_down_thresh    <= cfg_scale_down_thresh;
            end
            cfg_mask_p1        <= (cfg_valid && !cfg_reset) ? cfg_app_mask : '0;
            mon_config         <= cfg_mask_p1;
            mon_reset          <= flush;
            mon_arm_cong       <= (arm_valid && arm_cong) ? (NUM_APPS'(1) << arm_app_id) : '0;
            mon_arm_scale_down <= (arm_valid && arm_scale_down) ? (NUM_APPS'(1) << arm_app_id) : '0;
        end
    end

`ifdef NIC_MSG_ARB_STATS_EN
    logic [CNT_W-1:0] drop_num;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CNT_W-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Count pushes rejected by a full FIFO that is not popping this cycle
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            drop_num = drop_num + CNT_W'(mon_msg_en[i] && !flush[i] &&
                                         (fifo_cnt[i] == 2'd2) && !pop[i]);
        end
    end

    // Saturating drop counter and wrapping forward counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            fwd_cnt  <= '0;
        end else begin
            drop_cnt <= sat_add16(drop_cnt, drop_num);
            if (gnt) fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`else
    assign drop_cnt = '0;
    assign fwd_cnt  = '0;
`endif

endmodule

// File: tb/tb_nic_msg_arbiter.sv
// Testbench for nic_msg_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model of the arbiter's rules.
module tb_nic_msg_arbiter;

    localparam int AW = 2;
    localparam int NA = 4;
    localparam int MW = 64;
`ifdef NIC_MSG_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NA-1:0]   mon_msg_en = '0;
    logic [NA*MW-1:0] mon_msg = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [MW-1:0]   out_msg;
    logic [AW-1:0]   out_app_id;
    logic            cfg_valid = 1'b0;
    logic            cfg_reset = 1'b0;
    logic [NA-1:0]   cfg_app_mask = '0;
    logic [4:0]      cfg_scale_down_epoch_log = '0;
    logic [4:0]      cfg_cong_epoch_log = '0;
    logic [3:0]      cfg_scale_down_thresh = '0;
    logic [NA-1:0]   mon_config, mon_reset;
    logic [4:0]      mon_scale_down_epoch_log, mon_cong_epoch_log;
    logic [3:0]      mon_scale_down_thresh;
    logic            arm_valid = 1'b0;
    logic [AW-1:0]   arm_app_id = '0;
    logic            arm_cong = 1'b0;
    logic            arm_scale_down = 1'b0;
    logic [NA-1:0]   mon_arm_cong, mon_arm_scale_down;
    logic [15:0]     drop_cnt;
    logic [31:0]     fwd_cnt;

    nic_msg_arbiter #(.APP_ID_WIDTH(AW), .MSG_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .mon_msg_en(mon_msg_en), .mon_msg(mon_msg),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
        .out_app_id(out_app_id), .cfg_valid(cfg_valid), .cfg_reset(cfg_reset),
        .cfg_app_mask(cfg_app_mask),
        .cfg_scale_down_epoch_log(cfg_scale_down_epoch_log),
        .cfg_cong_epoch_log(cfg_cong_epoch_log),
        .cfg_scale_down_thresh(cfg_scale_down_thresh),
        .mon_config(mon_config), .mon_reset(mon_reset),
        .mon_scale_down_epoch_log(mon_scale_down_epoch_log),
        .mon_cong_epoch_log(mon_cong_epoch_log),
        .mon_scale_down_thresh(mon_scale_down_thresh),
        .arm_valid(arm_valid), .arm_app_id(arm_app_id), .arm_cong(arm_cong),
        .arm_scale_down(arm_scale_down), .mon_arm_cong(mon_arm_cong),
        .mon_arm_scale_down(mon_arm_scale_down), .drop_cnt(drop_cnt),
        .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [MW-1:0] mq [NA][$];
    bit            m_valid;
    logic [MW-1:0] m_msg;
    int            m_id;
    int            m_rr;
    int            m_drop;
    logic [31:0]   m_fwd;
    logic [NA-1:0] m_config, m_pend, m_reset, m_arm_c, m_arm_s;
    logic [4:0]    m_sd_log, m_cg_log;
    logic [3:0]    m_thresh;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < NA; a++) mq[a].delete();
        m_valid = 0; m_msg = '0; m_id = 0; m_rr = 0; m_drop = 0; m_fwd = '0;
        m_config = '0; m_pend = '0; m_reset = '0; m_arm_c = '0; m_arm_s = '0;
        m_sd_log = '0; m_cg_log = '0; m_thresh = '0;
    endtask

    // One clock of the arbiter's rules, computed from the inputs present before the edge
    task automatic model_step();
        logic [NA-1:0] fl;
        bit g;
        if (rst) begin
            model_reset();
            return;
        end
        fl = (cfg_valid && cfg_reset) ? cfg_app_mask : '0;
        g = 0;
        if (!m_valid || out_ready) begin
            for (int j = 0; j < NA; j++) begin
                int a;
                a = (m_rr + j) % NA;
                if (!g && mq[a].size() > 0 && !fl[a]) begin
                    g = 1;
                    m_msg = mq[a].pop_front();
                    m_id = a;
                    m_rr = (a + 1) % NA;
                    m_fwd = m_fwd + 1;
                end
            end
            m_valid = g;
        end
        for (int a = 0; a < NA; a++) begin
            if (fl[a]) mq[a].delete();
            else if (mon_msg_en[a]) begin
                if (mq[a].size() < 2) mq[a].push_back(mon_msg[a*MW +: MW]);
                else if (m_drop < 65535) m_drop++;
            end
        end
        m_config = m_pend;
        m_pend = (cfg_valid && !cfg_reset) ? cfg_app_mask : '0;
        if (cfg_valid && !cfg_reset) begin
            m_sd_log = cfg_scale_down_epoch_log;
            m_cg_log = cfg_cong_epoch_log;
            m_thresh = cfg_scale_down_thresh;
        end
        m_reset = fl;
        m_arm_c = (arm_valid && arm_cong) ? (NA'(1) << arm_app_id) : '0;
        m_arm_s = (arm_valid && arm_scale_down) ? (NA'(1) << arm_app_id) : '0;
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_msg", out_msg, m_msg);
            check("out_app_id", 64'(out_app_id), 64'(m_id));
        end
        check("mon_config", 64'(mon_config), 64'(m_config));
        check("mon_reset", 64'(mon_reset), 64'(m_reset));
        check("mon_sd_log", 64'(mon_scale_down_epoch_log), 64'(m_sd_log));
        check("mon_cg_log", 64'(mon_cong_epoch_log), 64'(m_cg_log));
        check("mon_thresh", 64'(mon_scale_down_thresh), 64'(m_thresh));
        check("mon_arm_cong", 64'(mon_arm_cong), 64'(m_arm_c));
        check("mon_arm_sd", 64'(mon_arm_scale_down), 64'(m_arm_s));
        check("drop_cnt", 64'(drop_cnt), STATS ? 64'(m_drop) : 64'd0);
        check("fwd_cnt", 64'(fwd_cnt), STATS ? 64'(m_fwd) : 64'd0);
    endtask

    // Advance one cycle, compare, then drop the one-cycle strobes
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        mon_msg_en = '0;
        cfg_valid = 1'b0;
        arm_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse(input int app, input logic [MW-1:0] msg);
        mon_msg_en[app] = 1'b1;
        mon_msg[app*MW +: MW] = msg;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fwd_cnt", 64'(fwd_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_mon_config", 64'(mon_config), 64'd0);

        // Single message from app 2: visible two cycles after the pulse
        out_ready = 1'b1;
        pulse(2, 64'h0001_0002_0000_0001);
        cyc();
        check("single_lat_t1", 64'(out_valid), 64'd0);
        cyc();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_msg", out_msg, 64'h0001_0002_0000_0001);
        check("single_id", 64'(out_app_id), 64'd2);
        check("single_fwd", 64'(fwd_cnt), STATS ? 64'd1 : 64'd0);
        cyc();

        // Fairness: two simultaneous bursts from all apps emerge 0,1,2,3 each time
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < NA; a++) pulse(a, 64'(100 * b + a));
            cyc();
            for (int a = 0; a < NA; a++) begin
                cyc();
                check("fair_id", 64'(out_app_id), 64'(a));
                check("fair_msg", out_msg, 64'(100 * b + a));
            end
        end
        cyc();
        check("fair_idle", 64'(out_valid), 64'd0);

        // Backpressure: four pulses from app 1 with ready low, the fourth is dropped
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pulse(1, 64'hA0 + 64'(k));
            cyc();
        end
        cyc();
        check("bp_stable_msg", out_msg, 64'hA0);
        check("bp_drop", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        out_ready = 1'b1;
        check("bp_out0", out_msg, 64'hA0);
        cyc();
        check("bp_out1", out_msg, 64'hA1);
        cyc();
        check("bp_out2", out_msg, 64'hA2);
        cyc();
        check("bp_done", 64'(out_valid), 64'd0);

        // Configure: bus at t+1, mask pulse at t+2 for one cycle
        cfg_valid = 1'b1; cfg_reset = 1'b0; cfg_app_mask = 4'b0101;
        cfg_scale_down_epoch_log = 5'd10; cfg_cong_epoch_log = 5'd12; cfg_scale_down_thresh = 4'd3;
        cyc();
        check("cfg_bus_sd", 64'(mon_scale_down_epoch_log), 64'd10);
        check("cfg_bus_cg", 64'(mon_cong_epoch_log), 64'd12);
        check("cfg_bus_th", 64'(mon_scale_down_thresh), 64'd3);
        check("cfg_pulse_t1", 64'(mon_config), 64'd0);
        cyc();
        check("cfg_pulse_t2", 64'(mon_config), 64'b0101);
        cyc();
        check("cfg_pulse_end", 64'(mon_config), 64'd0);

        // Reset flush of app 3 behind a held app-0 output entry
        do_reset();
        out_ready = 1'b0;
        pulse(0, 64'hB0);
        cyc();
        pulse(3, 64'hC1);
        cyc();
        pulse(3, 64'hC2);
        cyc();
        cyc();
        cfg_valid = 1'b1; cfg_reset = 1'b1; cfg_app_mask = 4'b1000;
        pulse(3, 64'hC3);
        cyc();
        check("flush_mon_reset", 64'(mon_reset), 64'b1000);
        check("flush_held_msg", out_msg, 64'hB0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("flush_no_app3", 64'(out_valid && out_app_id == 2'd3), 64'd0);
        end

        // Arm: cong pulse for app 1 only, one cycle
        arm_valid = 1'b1; arm_app_id = 2'd1; arm_cong = 1'b1; arm_scale_down = 1'b0;
        cyc();
        check("arm_cong", 64'(mon_arm_cong), 64'b0010);
        check("arm_sd", 64'(mon_arm_scale_down), 64'd0);
        cyc();
        check("arm_cong_end", 64'(mon_arm_cong), 64'd0);

        // Randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            for (int a = 0; a < NA; a++) begin
                mon_msg_en[a] = ($urandom_range(0, 99) < 35);
                mon_msg[a*MW +: MW] = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 99) < 60);
            cfg_valid = ($urandom_range(0, 99) < 6);
            cfg_reset = $urandom_range(0, 1) == 1;
            cfg_app_mask = NA'($urandom);
            cfg_scale_down_epoch_log = 5'($urandom);
            cfg_cong_epoch_log = 5'($urandom);
            cfg_scale_down_thresh = 4'($urandom);
            arm_valid = ($urandom_range(0, 99) < 10);
            arm_app_id = AW'($urandom);
            arm_cong = $urandom_range(0, 1) == 1;
            arm_scale_down = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                check("async_rst_valid", 64'(out_valid), 64'd0);
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
